// File: rtl/fwd_pipe_pkg.sv
// fwd_pipe shared definitions: defaults, legal depth range
// and the occupancy width helper.
package fwd_pipe_pkg;

  localparam int DWIDTH_DEF = 8;
  localparam int STAGES_DEF = 2;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 16;

  function automatic int occw(input int stages);
    return $clog2(stages + 1);
  endfunction

endpackage

// File: rtl/fwd_pipe_if.sv
// fwd_pipe stream interface: one valid/ready/data channel.
// master drives valid/data, slave drives ready.
interface fwd_pipe_if
  import fwd_pipe_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
);

  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/fwd_pipe_stage.sv
// fwd_stage: one forward-registered pipeline slot.
// Data only loads on a valid beat so bubbles never toggle it.
module fwd_stage
  import fwd_pipe_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              down_ready,
  output logic              up_ready,
  output logic              valid_q,
  output logic [DWIDTH-1:0] data_q
);

  assign up_ready = !valid_q || down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (up_ready) begin
      valid_q <= in_valid;
      if (in_valid) data_q <= in_data;
    end
  end

endmodule

// File: rtl/fwd_pipe.sv
// fwd_pipe: N-stage forward-registered stream pipe with flush
// and occupancy; FWD_PIPE_CHECK_EN adds the upstream checker.
module fwd_pipe
  import fwd_pipe_pkg::*;
#(
  parameter  int DWIDTH = DWIDTH_DEF,
  parameter  int STAGES = STAGES_DEF,
  localparam int OCCW   = occw(STAGES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  fwd_pipe_if.slave       m,
  fwd_pipe_if.master      s,
  output logic [OCCW-1:0] occupancy,
  output logic            proto_err
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad
    $error("fwd_pipe: STAGES outside legal range");
  end

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] adv_up;
  logic [STAGES-1:0] adv_dn;
  logic [DWIDTH-1:0] dat [STAGES];
  logic              m_ready;
  logic              in_hs;
  logic              out_hs;

  // adv_up[0] dominates every other tap, so the OR equals it
  assign m_ready = (|adv_up) && !rst && !flush;
  assign m.ready = m_ready;
  assign in_hs   = m.valid && m_ready;
  assign out_hs  = vld[STAGES-1] && s.ready;
  assign s.valid = vld[STAGES-1];
  assign s.data  = dat[STAGES-1];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic              in_v;
    logic [DWIDTH-1:0] in_d;

    if (i == 0) begin : g_head
      assign in_v = in_hs;
      assign in_d = m.data;
    end else begin : g_body
      assign in_v = vld[i-1];
      assign in_d = dat[i-1];
    end

    // ready from below, flattened so there is no comb chain
    if (i == STAGES - 1) begin : g_tail
      assign adv_dn[i] = s.ready;
    end else begin : g_mid
      assign adv_dn[i] = s.ready || !(&vld[STAGES-1:i+1]);
    end

    fwd_stage #(
      .DWIDTH(DWIDTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_v),
      .in_data   (in_d),
      .down_ready(adv_dn[i]),
      .up_ready  (adv_up[i]),
      .valid_q   (vld[i]),
      .data_q    (dat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else begin
      occupancy <= occupancy + OCCW'(in_hs) - OCCW'(out_hs);
    end
  end

`ifdef FWD_PIPE_CHECK_EN
  logic              stall_d;
  logic [DWIDTH-1:0] data_d;
  logic              viol;

  assign viol = stall_d && (!m.valid || m.data != data_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_d   <= 1'b0;
      data_d    <= '0;
      proto_err <= 1'b0;
    end else begin
      stall_d   <= m.valid && !m_ready;
      data_d    <= m.data;
      proto_err <= proto_err || viol;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && stall_d) begin
      assert (m.valid)
        else $warning("fwd_pipe: m_valid dropped before handshake");
      assert (!m.valid || m.data == data_d)
        else $warning("fwd_pipe: m_data changed while stalled");
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_fwd_pipe.sv
// tb_fwd_pipe: table vectors on a 2-stage pipe, hand sequences
// on a 3-stage pipe, queue scoreboards on both outputs.
module tb_fwd_pipe;
  import fwd_pipe_pkg::*;

`ifdef FWD_PIPE_CHECK_EN
  localparam logic EXP_PE = 1'b1;
`else
  localparam logic EXP_PE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fl2 = 1'b0;
  logic fl3 = 1'b0;
  logic [occw(2)-1:0] occ2;
  logic [occw(3)-1:0] occ3;
  logic pe2, pe3;

  fwd_pipe_if #(.DWIDTH(8)) m2 ();
  fwd_pipe_if #(.DWIDTH(8)) s2 ();
  fwd_pipe_if #(.DWIDTH(8)) m3 ();
  fwd_pipe_if #(.DWIDTH(8)) s3 ();

  fwd_pipe #(.DWIDTH(8), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .flush(fl2), .m(m2), .s(s2),
    .occupancy(occ2), .proto_err(pe2)
  );

  fwd_pipe #(.DWIDTH(8), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .flush(fl3), .m(m3), .s(s3),
    .occupancy(occ3), .proto_err(pe3)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  typedef struct {
    bit       mv;
    bit [7:0] d;
    bit       sr;
    bit       fl;
    bit       e_mr;
    bit       e_sv;
    bit [7:0] e_sd;
    bit [1:0] e_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int mv, int d, int sr, int fl,
                              int mr, int sv, int sd, int oc);
    vec_t r;
    r.mv = 1'(mv); r.d = 8'(d); r.sr = 1'(sr); r.fl = 1'(fl);
    r.e_mr = 1'(mr); r.e_sv = 1'(sv); r.e_sd = 8'(sd);
    r.e_occ = 2'(oc);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      q2.delete();
    end else begin
      if (s2.valid && s2.ready) begin
        if (q2.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb2 extra: got 0x%0h, none expected", s2.data);
        end else chk("sb2 data", s2.data, q2.pop_front());
      end
      if (fl2) q2.delete();
      else if (m2.valid && m2.ready) q2.push_back(m2.data);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q3.delete();
    end else begin
      if (s3.valid && s3.ready) begin
        if (q3.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb3 extra: got 0x%0h, none expected", s3.data);
        end else chk("sb3 data", s3.data, q3.pop_front());
      end
      if (fl3) q3.delete();
      else if (m3.valid && m3.ready) q3.push_back(m3.data);
    end
  end

  task automatic drain3();
    m3.valid = 1'b0;
    s3.ready = 1'b1;
    for (int i = 0; i < 12 && q3.size() != 0; i++) to_pos();
    chk("drain3 queue", q3.size(), 0);
    @(negedge clk);
    chk("drain3 occ", occ3, 0);
    chk("drain3 sv", s3.valid, 0);
    to_pos();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic hs;
    int   acc;
    m2.valid = 1'b0; m2.data = '0; s2.ready = 1'b0;
    m3.valid = 1'b0; m3.data = '0; s3.ready = 1'b0;

    //        mv  d    sr fl  mr sv sd   occ
    tbl.push_back(mk(1, 'h11, 1, 0, 1, 0, 'h00, 0));
    tbl.push_back(mk(1, 'h22, 1, 0, 1, 0, 'h00, 1));
    tbl.push_back(mk(1, 'h33, 1, 0, 1, 1, 'h11, 2));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 'h22, 2));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 'h33, 1));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 0, 'h00, 0));
    tbl.push_back(mk(1, 'h44, 0, 0, 1, 0, 'h00, 0));
    tbl.push_back(mk(1, 'h55, 0, 0, 1, 0, 'h00, 1));
    tbl.push_back(mk(1, 'h66, 0, 0, 0, 1, 'h44, 2));
    tbl.push_back(mk(1, 'h66, 0, 1, 0, 1, 'h44, 2));
    tbl.push_back(mk(1, 'h66, 0, 0, 1, 0, 'h00, 0));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 0, 'h00, 1));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 1, 'h66, 1));
    tbl.push_back(mk(0, 'h00, 1, 0, 1, 0, 'h00, 0));

    repeat (2) to_pos();
    @(negedge clk);
    chk("rst s2.valid", s2.valid, 0);
    chk("rst s2.data", s2.data, 0);
    chk("rst occ2", occ2, 0);
    chk("rst m2.ready", m2.ready, 0);
    chk("rst pe2", pe2, 0);
    chk("rst s3.valid", s3.valid, 0);
    chk("rst occ3", occ3, 0);
    chk("rst m3.ready", m3.ready, 0);
    to_pos();
    rst = 1'b0;

    foreach (tbl[i]) begin
      m2.valid = tbl[i].mv;
      m2.data  = tbl[i].d;
      s2.ready = tbl[i].sr;
      fl2      = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d m_ready", i), m2.ready, tbl[i].e_mr);
      chk($sformatf("vec%0d s_valid", i), s2.valid, tbl[i].e_sv);
      chk($sformatf("vec%0d occ", i), occ2, tbl[i].e_occ);
      if (tbl[i].e_sv)
        chk($sformatf("vec%0d s_data", i), s2.data, tbl[i].e_sd);
      to_pos();
    end
    chk("tbl sb2 empty", q2.size(), 0);

    // stalled fill of the 3-stage pipe, then release
    s3.ready = 1'b0;
    m3.valid = 1'b1;
    m3.data  = 8'hA0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = m3.ready;
      if (hs) acc++;
      if (c >= 3) begin
        chk("stall s_valid", s3.valid, 1);
        chk("stall s_data", s3.data, 'hA0);
      end
      to_pos();
      if (hs) m3.data = m3.data + 8'd1;
    end
    @(negedge clk);
    chk("fill accepted", acc, 3);
    chk("full m_ready", m3.ready, 0);
    chk("full occ", occ3, 3);
    to_pos();
    s3.ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      hs = m3.ready;
      if (c == 0) chk("full+sr m_ready", m3.ready, 1);
      if (c == 1) chk("full+sr occ", occ3, 3);
      to_pos();
      if (hs) m3.data = m3.data + 8'd1;
    end
    drain3();

    // bubble collapse behind a stalled output
    s3.ready = 1'b0;
    m3.valid = 1'b1;
    m3.data  = 8'h5A;
    @(negedge clk);
    chk("bub 5A m_ready", m3.ready, 1);
    to_pos();
    m3.valid = 1'b0;
    to_pos();
    to_pos();
    @(negedge clk);
    chk("bub last s_valid", s3.valid, 1);
    chk("bub last s_data", s3.data, 'h5A);
    chk("bub occ1", occ3, 1);
    to_pos();
    m3.valid = 1'b1;
    m3.data  = 8'h5B;
    @(negedge clk);
    chk("bub 5B m_ready", m3.ready, 1);
    to_pos();
    m3.data = 8'h5C;
    @(negedge clk);
    chk("bub occ2", occ3, 2);
    chk("bub hold data", s3.data, 'h5A);
    to_pos();
    m3.data = 8'h5D;
    @(negedge clk);
    chk("bub full m_ready", m3.ready, 0);
    chk("bub full occ", occ3, 3);
    to_pos();
    s3.ready = 1'b1;
    @(negedge clk);
    chk("bub full+sr m_ready", m3.ready, 1);
    to_pos();
    m3.valid = 1'b0;
    @(negedge clk);
    chk("bub in+out occ", occ3, 3);
    to_pos();
    drain3();

    // upstream changes data while stalled
    s3.ready = 1'b0;
    m3.valid = 1'b1;
    m3.data  = 8'h0D;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      hs = m3.ready;
      to_pos();
      if (hs) m3.data = m3.data + 8'd1;
    end
    @(negedge clk);
    chk("proto stall m_ready", m3.ready, 0);
    chk("proto stall data", m3.data, 'h10);
    chk("proto before", pe3, 0);
    to_pos();
    m3.data = 8'h20;
    to_pos();
    @(negedge clk);
    chk("proto set", pe3, EXP_PE);
    repeat (3) to_pos();
    @(negedge clk);
    chk("proto sticky", pe3, EXP_PE);
    chk("proto dut2 clean", pe2, 0);
    to_pos();
    rst = 1'b1;
    m3.valid = 1'b0;
    @(negedge clk);
    chk("midrst m_ready", m3.ready, 0);
    to_pos();
    rst = 1'b0;
    @(negedge clk);
    chk("post rst pe3", pe3, 0);
    chk("post rst s_valid", s3.valid, 0);
    chk("post rst occ", occ3, 0);
    to_pos();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
